serial_pair_transmitter: RTL

- Parallel-to-serial transmitter for operand pairs.
- Accepts two WIDTH-bit words (in_a, in_b) over a valid/ready handshake.
- Shifts both words out one bit per clock on lines a and b, in lock-step, with framing strobes.
- Feeds the team's serial comparators (MSB-first or LSB-first) and any other bit-serial consumer.

---
 rtl/serial_pair_pkg.sv | 17 +
 rtl/serial_pair_transmitter_if.sv | 23 ++
 rtl/piso_shift_reg.sv | 33 +++
 rtl/serial_pair_transmitter.sv | 105 ++++++++++
 4 files changed

// File: rtl/serial_pair_pkg.sv
// Shared types and helpers for the serial pair transmitter: FSM state encoding
// and the bit-counter width rule.
package serial_pair_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // The counter must hold WIDTH-1 and never collapse to zero bits when WIDTH is 1.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_pair_transmitter_if.sv
// Parallel word-pair handshake plus the framed bit-serial output of the
// serial pair transmitter.
interface serial_pair_transmitter_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             a;
    logic             b;
    logic             out_valid;
    logic             out_first;
    logic             out_last;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, a, b, out_valid, out_first, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, a, b, out_valid, out_first, out_last
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; the serial bit is taken straight from
// the output-end flop and zeros are shifted in behind the data.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_bit
);
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    logic [WIDTH-1:0] sr_r;

    // Load has priority over shift so a back-to-back reload wins on the last bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r <= {WIDTH{1'b0}};
        end else if (load) begin
            sr_r <= d;
        end else if (shift) begin
            sr_r <= (MSB_FIRST != 0) ? (sr_r << 1'b1) : (sr_r >> 1'b1);
        end else begin
            sr_r <= sr_r;
        end
    end

    assign q_bit = sr_r[OUT_IDX];

endmodule

// File: rtl/serial_pair_transmitter.sv
// Serialises operand pairs onto lines a/b in lock-step with first/last framing.
// Build option: SERIAL_PAIR_TX_BACK_TO_BACK_EN allows reload on the last bit.
module serial_pair_transmitter
    import serial_pair_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_pair_transmitter_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             load_s;
    logic             shift_s;
    logic             ready_s;

    // State and bit-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, counter update and shift-register control.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        ready_s      = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (bus.in_valid) begin
                    load_s       = 1'b1;
                    cnt_next_s   = CNT_TOP;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == CNT_ZERO) begin
`ifdef SERIAL_PAIR_TX_BACK_TO_BACK_EN
                    ready_s = 1'b1;
                    if (bus.in_valid) begin
                        load_s       = 1'b1;
                        cnt_next_s   = CNT_TOP;
                        next_state_s = SHIFT;
                    end else begin
                        next_state_s = IDLE;
                    end
`else
                    next_state_s = IDLE;
`endif
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .d     (bus.in_a),
        .q_bit (bus.a)
    );

    piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .d     (bus.in_b),
        .q_bit (bus.b)
    );

    // in_ready is gated by rst so it stays low for the whole reset window.
    assign bus.in_ready  = ready_s & rst;
    assign bus.out_valid = (state_r == SHIFT);
    assign bus.out_first = (state_r == SHIFT) && (cnt_r == CNT_TOP);
    assign bus.out_last  = (state_r == SHIFT) && (cnt_r == CNT_ZERO);

endmodule
